// File: rtl/max_pool_addr_gen.sv
// max_pool_addr_gen
// ------------------------------------------------------------------------
// Read-address generator for the max-pooling stage. Walks every pooling
// window of a CHANNELS x IMG_H x IMG_W row-major feature map (loop order
// c, oy, ox, ky, kx) and issues one tap address per accepted handshake.
// A MEM_LATENCY-deep sideband pipeline carries {one-hot tap select, first,
// last} so it lines up with the data returning from feature memory.
// Addresses come from incremental plane/row/window/tap bases, so the
// per-tap path contains adders only.
//
// Optional feature: define MAXPOOL_START_ERR_EN to add the sticky `err`
// output, which flags a start request that arrives while a pass is running
// or draining.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           one-cycle pass request (honoured in IDLE or DONE)
//   base_addr       map base address, sampled on an accepted start
//   addr_out        registered tap address
//   addr_valid      addr_out is valid
//   addr_ready      memory accepts addr_out
//   sel             one-hot tap index ky*POOL_K+kx, aligned to memory data
//   sel_valid       sideband valid, aligned to memory data
//   win_first       sideband entry is tap 0 of a window
//   win_last        sideband entry is the final tap of a window
//   busy            high while running or draining
//   done            high once the pass has fully drained
//   err             (MAXPOOL_START_ERR_EN only) sticky ignored-start flag
// ------------------------------------------------------------------------
module max_pool_addr_gen #(
  parameter int IMG_W       = 4,
  parameter int IMG_H       = 4,
  parameter int POOL_K      = 2,
  parameter int STRIDE      = 2,
  parameter int CHANNELS    = 1,
  parameter int ADDR_W      = 14,
  parameter int MEM_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic [ADDR_W-1:0]          addr_out,
  output logic                       addr_valid,
  input  logic                       addr_ready,
  output logic [POOL_K*POOL_K-1:0]   sel,
  output logic                       sel_valid,
  output logic                       win_first,
  output logic                       win_last,
  output logic                       busy,
  output logic                       done
`ifdef MAXPOOL_START_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int KK    = POOL_K * POOL_K;
  localparam int OUT_W = (IMG_W - POOL_K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - POOL_K) / STRIDE + 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  K_LAST   = CNT_W'(POOL_K - 1);
  localparam logic [CNT_W-1:0]  OX_LAST  = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0]  OY_LAST  = CNT_W'(OUT_H - 1);
  localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(CHANNELS - 1);

  // Address increments; all are elaboration-time constants.
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] COL_STEP     = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] WIN_ROW_STEP = ADDR_W'(STRIDE * IMG_W);
  localparam logic [ADDR_W-1:0] PLANE_STEP   = ADDR_W'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_r;

  logic [CNT_W-1:0]    c_r, oy_r, ox_r, ky_r, kx_r;
  logic [ADDR_W-1:0]   plane_base_r;  // base + c*IMG_W*IMG_H
  logic [ADDR_W-1:0]   win_row_r;     // plane_base + oy*STRIDE*IMG_W
  logic [ADDR_W-1:0]   win_base_r;    // win_row + ox*STRIDE
  logic [ADDR_W-1:0]   tap_row_r;     // win_base + ky*IMG_W
  logic [KK-1:0]       tap_sel_r;     // one-hot of the tap currently on addr_out

  logic [MEM_LATENCY-1:0]         sb_valid_r;
  logic [MEM_LATENCY-1:0][KK-1:0] sb_sel_r;
  logic [MEM_LATENCY-1:0]         sb_first_r;
  logic [MEM_LATENCY-1:0]         sb_last_r;

  logic                accept_s;
  logic                pass_end_s;
  logic                upstream_busy_s;
  logic [CNT_W-1:0]    c_nxt_s, oy_nxt_s, ox_nxt_s, ky_nxt_s, kx_nxt_s;
  logic [ADDR_W-1:0]   plane_nxt_s, win_row_nxt_s, win_base_nxt_s, tap_row_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;

  assign accept_s  = addr_valid & addr_ready;
  assign sel       = sb_sel_r[MEM_LATENCY-1];
  assign sel_valid = sb_valid_r[MEM_LATENCY-1];
  assign win_first = sb_first_r[MEM_LATENCY-1];
  assign win_last  = sb_last_r[MEM_LATENCY-1];

  // Pipeline stages that still feed the output stage; when they are all
  // empty the output stage is on its final entry and DONE can follow.
  always_comb begin
    upstream_busy_s = 1'b0;
    for (int i = 0; i < MEM_LATENCY - 1; i++) begin
      upstream_busy_s = upstream_busy_s | sb_valid_r[i];
    end
  end

  // Next tap position: innermost counter that has not wrapped advances and
  // every base beneath it restarts from the updated base.
  always_comb begin
    c_nxt_s        = c_r;
    oy_nxt_s       = oy_r;
    ox_nxt_s       = ox_r;
    ky_nxt_s       = ky_r;
    kx_nxt_s       = kx_r;
    plane_nxt_s    = plane_base_r;
    win_row_nxt_s  = win_row_r;
    win_base_nxt_s = win_base_r;
    tap_row_nxt_s  = tap_row_r;
    addr_nxt_s     = addr_out;
    pass_end_s     = 1'b0;
    if (kx_r != K_LAST) begin
      kx_nxt_s   = kx_r + CNT_ONE;
      addr_nxt_s = addr_out + ADDR_ONE;
    end else if (ky_r != K_LAST) begin
      kx_nxt_s      = '0;
      ky_nxt_s      = ky_r + CNT_ONE;
      tap_row_nxt_s = tap_row_r + ROW_STEP;
      addr_nxt_s    = tap_row_r + ROW_STEP;
    end else if (ox_r != OX_LAST) begin
      kx_nxt_s       = '0;
      ky_nxt_s       = '0;
      ox_nxt_s       = ox_r + CNT_ONE;
      win_base_nxt_s = win_base_r + COL_STEP;
      tap_row_nxt_s  = win_base_r + COL_STEP;
      addr_nxt_s     = win_base_r + COL_STEP;
    end else if (oy_r != OY_LAST) begin
      kx_nxt_s       = '0;
      ky_nxt_s       = '0;
      ox_nxt_s       = '0;
      oy_nxt_s       = oy_r + CNT_ONE;
      win_row_nxt_s  = win_row_r + WIN_ROW_STEP;
      win_base_nxt_s = win_row_r + WIN_ROW_STEP;
      tap_row_nxt_s  = win_row_r + WIN_ROW_STEP;
      addr_nxt_s     = win_row_r + WIN_ROW_STEP;
    end else if (c_r != C_LAST) begin
      kx_nxt_s       = '0;
      ky_nxt_s       = '0;
      ox_nxt_s       = '0;
      oy_nxt_s       = '0;
      c_nxt_s        = c_r + CNT_ONE;
      plane_nxt_s    = plane_base_r + PLANE_STEP;
      win_row_nxt_s  = plane_base_r + PLANE_STEP;
      win_base_nxt_s = plane_base_r + PLANE_STEP;
      tap_row_nxt_s  = plane_base_r + PLANE_STEP;
      addr_nxt_s     = plane_base_r + PLANE_STEP;
    end else begin
      // Final tap of the final window: counters return to zero.
      kx_nxt_s   = '0;
      ky_nxt_s   = '0;
      ox_nxt_s   = '0;
      oy_nxt_s   = '0;
      c_nxt_s    = '0;
      pass_end_s = 1'b1;
    end
  end

  // Sideband shift register: loaded with the accepted tap every cycle
  // (zeros when nothing is accepted) and never stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_valid_r <= '0;
      sb_sel_r   <= '0;
      sb_first_r <= '0;
      sb_last_r  <= '0;
    end else begin
      sb_valid_r[0] <= accept_s;
      sb_sel_r[0]   <= accept_s ? tap_sel_r : {KK{1'b0}};
      sb_first_r[0] <= accept_s & tap_sel_r[0];
      sb_last_r[0]  <= accept_s & tap_sel_r[KK-1];
      for (int i = 1; i < MEM_LATENCY; i++) begin
        sb_valid_r[i] <= sb_valid_r[i-1];
        sb_sel_r[i]   <= sb_sel_r[i-1];
        sb_first_r[i] <= sb_first_r[i-1];
        sb_last_r[i]  <= sb_last_r[i-1];
      end
    end
  end

  // Pass control FSM with registered address, handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      c_r          <= '0;
      oy_r         <= '0;
      ox_r         <= '0;
      ky_r         <= '0;
      kx_r         <= '0;
      plane_base_r <= '0;
      win_row_r    <= '0;
      win_base_r   <= '0;
      tap_row_r    <= '0;
      tap_sel_r    <= '0;
      addr_out     <= '0;
      addr_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef MAXPOOL_START_ERR_EN
      err          <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r      <= S_RUN;
            c_r          <= '0;
            oy_r         <= '0;
            ox_r         <= '0;
            ky_r         <= '0;
            kx_r         <= '0;
            plane_base_r <= base_addr;
            win_row_r    <= base_addr;
            win_base_r   <= base_addr;
            tap_row_r    <= base_addr;
            tap_sel_r    <= {{(KK-1){1'b0}}, 1'b1};
            addr_out     <= base_addr;
            addr_valid   <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
`ifdef MAXPOOL_START_ERR_EN
            err          <= 1'b0;
`endif
          end
        end
        S_RUN: begin
`ifdef MAXPOOL_START_ERR_EN
          if (start) begin
            err <= 1'b1;
          end
`endif
          if (accept_s) begin
            c_r          <= c_nxt_s;
            oy_r         <= oy_nxt_s;
            ox_r         <= ox_nxt_s;
            ky_r         <= ky_nxt_s;
            kx_r         <= kx_nxt_s;
            plane_base_r <= plane_nxt_s;
            win_row_r    <= win_row_nxt_s;
            win_base_r   <= win_base_nxt_s;
            tap_row_r    <= tap_row_nxt_s;
            addr_out     <= addr_nxt_s;
            // Every window has exactly KK taps, so rotation returns to tap 0.
            tap_sel_r    <= {tap_sel_r[KK-2:0], tap_sel_r[KK-1]};
            if (pass_end_s) begin
              state_r    <= S_DRAIN;
              addr_valid <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
`ifdef MAXPOOL_START_ERR_EN
          if (start) begin
            err <= 1'b1;
          end
`endif
          if (!upstream_busy_s) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          addr_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/max_pool_addr_gen.md
# max_pool_addr_gen

Parametrised read-address generator for the max-pooling stage. It walks every pooling window of a CHANNELS × IMG_H × IMG_W feature map stored row-major in feature memory and issues one tap address per cycle under a valid/ready handshake. It also emits a latency-aligned sideband (one-hot tap select plus first/last window flags) that lines up with returning memory data for the downstream comparator. Pool size, stride, map size, channel count and memory latency are all parameters.

## Interface
- IMG_W, 4: input map width (≥ POOL_K)
- IMG_H, 4: input map height (≥ POOL_K)
- POOL_K, 2: square window edge, 2..4
- STRIDE, 2: window step, 1..POOL_K
- CHANNELS, 1: number of planes, ≥1
- ADDR_W, 14: address width
- MEM_LATENCY, 2: cycles from accepted address to valid memory data, 1..8

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request to begin a pass (honoured in IDLE or DONE)
- base_addr  in  ADDR_W  map base; sampled on accepted start
- addr_out  out  ADDR_W  tap address
- addr_valid  out  1  addr_out is valid
- addr_ready  in  1  memory accepts addr_out
- sel  out  POOL_K*POOL_K  one-hot tap index ky*POOL_K+kx, aligned to memory data
- sel_valid  out  1  sideband valid, aligned to memory data
- win_first  out  1  sideband is tap 0 of a window
- win_last  out  1  sideband is the final tap of a window
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE

## Operation
- OUT_W = (IMG_W−POOL_K)/STRIDE+1, OUT_H likewise (integer floor). TOTAL = CHANNELS·OUT_H·OUT_W·POOL_K².
- Loop order, outermost first: c, oy, ox, ky, kx.
- addr_out = base + c·IMG_W·IMG_H + (oy·STRIDE+ky)·IMG_W + ox·STRIDE + kx, computed modulo 2^ADDR_W. Wrap is silent.
- Counters use incremental row/column offsets. Multipliers in the per-tap path are forbidden.
- FSM states:
  - IDLE: start → RUN, and base_addr is latched.
  - RUN: counters advance only on addr_valid && addr_ready. Acceptance of the TOTAL-th address → DRAIN.
  - DRAIN: wait until the sideband pipeline is empty → DONE.
  - DONE: start → RUN (new pass, counters cleared).
- start is ignored in RUN and DRAIN.
- Sideband is a MEM_LATENCY-deep shift register loaded on every accepted address with {sel, first, last}. It shifts every cycle and cannot stall.
- win_first is set when ky=kx=0. win_last is set when ky=kx=POOL_K−1.

## Timing
- Reset values: addr_out=0, addr_valid=0, sel=0, sel_valid=0, win_first=0, win_last=0, busy=0, done=0. FSM is in IDLE and all counters are 0.
- addr_valid rises the cycle after an accepted start. addr_out is registered.
- addr_out is held stable while addr_valid && !addr_ready.
- Sideband for an address accepted at cycle t appears at t+MEM_LATENCY.
- With addr_ready held high, one address is issued per cycle. done rises at start+1+TOTAL+MEM_LATENCY.
- addr_valid drops the cycle after the last acceptance.
- Reset asserted mid-pass clears all state immediately, and the sideband pipeline is flushed. No partial window is reported after release.

## Configuration
- MAXPOOL_START_ERR_EN defined: adds output `err` (1 bit, reset 0).
  - `err` is set sticky by start arriving in RUN or DRAIN.
  - `err` is cleared only by an accepted start in IDLE/DONE, or by reset.
- MAXPOOL_START_ERR_EN undefined: no `err` port. Such starts are silently ignored.

## Test plan
- Defaults, base_addr=100, ready=1. Required order: 100,101,104,105, then 102,103,106,107, then 108,109,112,113, then 110,111,114,115. sel is 1,2,4,8 repeating. done rises at cycle 1+16+2 after start.
- IMG_W=IMG_H=3, POOL_K=2, STRIDE=1, base 0. Required sequence: 0,1,3,4, 1,2,4,5, 3,4,6,7, 4,5,7,8. win_last is high on every 4th sideband entry.
- Defaults with addr_ready toggling 1,0,0,1 repeating. addr_out stays stable during stalls. Sideband still arrives exactly 2 cycles after each acceptance. Same 16-address sequence as above.
- CHANNELS=2, base 0. The second plane starts at 16 (16,17,20,21). TOTAL=32.
- Reset pulsed after 5 accepted addresses. All outputs return to 0 within the reset cycle. A following start with base 0 restarts from address 0.
- With MAXPOOL_START_ERR_EN: start pulsed in RUN → err=1 and the pass is unaffected. Start in DONE → err clears and a new pass begins.
